// File: rtl/io_bus_pkg.sv
// Shared definitions for the two-master IO bus arbiter: state encoding,
// default bus widths and the memory-mapped IO port addresses.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [DEF_ADDR_W-1:0] INPUT_PORT  = 10'h3FE;
  localparam logic [DEF_ADDR_W-1:0] OUTPUT_PORT = 10'h3FF;

endpackage

// File: rtl/arb_grant_counter.sv
// Owner-cycle counter for the arbiter's forced-release timeout.
// Cleared on every ownership change, saturates at TIMEOUT. expired_c is high
// during the TIMEOUT-th (or any later) cycle of the current ownership, so
// the release happens on the edge where the count reaches TIMEOUT.
module arb_grant_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired_c
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count owner cycles, restart on handover, hold at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = (cnt >= LAST);

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master (CPU = 0, loader = 1) arbiter for a shared IO bus.
// Grants are state-derived; bus strobes/address/data are muxed from the
// current owner; read data is captured per master.
// Optional macro ARB_TIMEOUT_EN: forced release of an unlocked owner after
// TIMEOUT consecutive grant cycles when the other master is waiting.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_req0,
  input  logic              in_req1,
  input  logic              in_we0,
  input  logic              in_we1,
  input  logic              in_re0,
  input  logic              in_re1,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_wdata0,
  input  logic [DATA_W-1:0] in_wdata1,
  input  logic              in_lock0,
  input  logic              in_lock1,
  input  logic [DATA_W-1:0] in_bus_data,
  output logic              out_gnt0,
  output logic              out_gnt1,
  output logic              out_write_en,
  output logic              out_read_en,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_rdata0,
  output logic [DATA_W-1:0] out_rdata1
);

  arb_state_t state;
  arb_state_t state_next;
  logic       last;
  logic       last_next;
  logic       release0;
  logic       release1;

`ifdef ARB_TIMEOUT_EN
  logic owning;
  logic changed;
  logic expired_c;

  assign owning  = (state != IDLE);
  assign changed = (state_next != state);

  arb_grant_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_grant_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (owning),
    .clr       (changed),
    .expired_c (expired_c)
  );

  // An owner may be forced off only when it has not asked for a lock.
  assign release0 = expired_c & ~in_lock0;
  assign release1 = expired_c & ~in_lock1;
`else
  logic unused_cfg;

  assign release0   = 1'b0;
  assign release1   = 1'b0;
  assign unused_cfg = ^{in_lock0, in_lock1, 4'(TIMEOUT)};
`endif

  // State and last-served registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Ownership transitions; tie from IDLE goes to the master not served last.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (in_req0 && in_req1) begin
          state_next = last ? OWN0 : OWN1;
        end else if (in_req0) begin
          state_next = OWN0;
        end else if (in_req1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!in_req0) begin
          state_next = in_req1 ? OWN1 : IDLE;
        end else if (in_req1 && release0) begin
          state_next = OWN1;
        end
      end
      OWN1: begin
        if (!in_req1) begin
          state_next = in_req0 ? OWN0 : IDLE;
        end else if (in_req0 && release1) begin
          state_next = OWN0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == OWN0) begin
      last_next = 1'b0;
    end else if (state_next == OWN1) begin
      last_next = 1'b1;
    end
  end

  assign out_gnt0 = (state == OWN0);
  assign out_gnt1 = (state == OWN1);

  // Owner-only bus mux; write wins over read, reset kills strobes at once.
  always_comb begin
    out_write_en = 1'b0;
    out_read_en  = 1'b0;
    out_addr     = '0;
    out_data     = '0;
    case (state)
      OWN0: begin
        out_write_en = in_req0 & in_we0;
        out_read_en  = in_req0 & in_re0 & ~in_we0;
        out_addr     = in_addr0;
        out_data     = in_wdata0;
      end
      OWN1: begin
        out_write_en = in_req1 & in_we1;
        out_read_en  = in_req1 & in_re1 & ~in_we1;
        out_addr     = in_addr1;
        out_data     = in_wdata1;
      end
      default: ;
    endcase
    if (rst) begin
      out_write_en = 1'b0;
      out_read_en  = 1'b0;
    end
  end

  // Capture returned read data into the owner's register only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rdata0 <= '0;
      out_rdata1 <= '0;
    end else if (out_read_en) begin
      if (state == OWN0) begin
        out_rdata0 <= in_bus_data;
      end
      if (state == OWN1) begin
        out_rdata1 <= in_bus_data;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized
// traffic checked against a cycle-level ownership model. Honors ARB_TIMEOUT_EN.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  localparam int TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1, re0, re1, lock0, lock1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, bus_data;
  logic       gnt0, gnt1, write_en, read_en;
  logic [9:0] addr;
  logic [7:0] data, rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  // Model: owner id (-1 none), last served id, cycles of current ownership.
  int         m_own;
  int         m_last;
  int         m_cycles;
  logic [7:0] m_rd0, m_rd1;

  io_bus_arbiter #(.ADDR_W(10), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_req0(req0), .in_req1(req1), .in_we0(we0), .in_we1(we1),
    .in_re0(re0), .in_re1(re1), .in_addr0(addr0), .in_addr1(addr1),
    .in_wdata0(wdata0), .in_wdata1(wdata1), .in_lock0(lock0), .in_lock1(lock1),
    .in_bus_data(bus_data),
    .out_gnt0(gnt0), .out_gnt1(gnt1), .out_write_en(write_en), .out_read_en(read_en),
    .out_addr(addr), .out_data(data), .out_rdata0(rdata0), .out_rdata1(rdata1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_own = -1; m_last = 1; m_cycles = 0; m_rd0 = '0; m_rd1 = '0;
  endtask

  task automatic model_edge();
    logic r [2];
    logic lk [2];
    int   nxt;
    r[0] = req0; r[1] = req1; lk[0] = lock0; lk[1] = lock1;
    if (m_own == 0 && req0 && re0 && !we0) m_rd0 = bus_data;
    if (m_own == 1 && req1 && re1 && !we1) m_rd1 = bus_data;
    if (m_own < 0) begin
      if (r[0] && r[1]) nxt = 1 - m_last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = -1;
    end else if (!r[m_own]) begin
      nxt = r[1-m_own] ? 1 - m_own : -1;
    end else if (TO_EN && m_cycles >= TIMEOUT && r[1-m_own] && !lk[m_own]) begin
      nxt = 1 - m_own;
    end else begin
      nxt = m_own;
    end
    if (nxt != m_own) begin
      m_cycles = (nxt >= 0) ? 1 : 0;
      if (nxt >= 0) m_last = nxt;
    end else if (m_own >= 0) begin
      m_cycles++;
    end
    m_own = nxt;
  endtask

  function automatic logic exp_we();
    if (m_own == 0) return req0 & we0;
    if (m_own == 1) return req1 & we1;
    return 1'b0;
  endfunction

  function automatic logic exp_re();
    if (m_own == 0) return req0 & re0 & ~we0;
    if (m_own == 1) return req1 & re1 & ~we1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] exp_addr();
    if (m_own == 0) return addr0;
    if (m_own == 1) return addr1;
    return '0;
  endfunction

  function automatic logic [7:0] exp_data();
    if (m_own == 0) return wdata0;
    if (m_own == 1) return wdata1;
    return '0;
  endfunction

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; re0 = 0; re1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; bus_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #3;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); end
    checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 00/00", rdata0, rdata1); end
    checks++; if (write_en !== 1'b0 || read_en !== 1'b0 || addr !== 10'h000) begin errors++; $display("FAIL reset_bus: got we=%b re=%b addr=%h expected 0 0 000", write_en, read_en, addr); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b%b expected 00", gnt0, gnt1); end
  endtask

  task automatic test_single_write();
    do_reset();
    req0 = 1; we0 = 1; addr0 = OUTPUT_PORT; wdata0 = 8'h8C;
    #1;
    checks++; if (gnt0 !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL write_pre_grant: got gnt0=%b we=%b expected 0 0", gnt0, write_en); end
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL write_grant: got %b%b expected 10", gnt0, gnt1); end
    checks++; if (write_en !== 1'b1 || addr !== 10'h3FF || data !== 8'h8C) begin errors++; $display("FAIL write_bus: got we=%b addr=%h data=%h expected 1 3ff 8c", write_en, addr, data); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL tie_first: got %b%b expected 10", gnt0, gnt1); end
    req0 = 0;
    tick();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errors++; $display("FAIL handover_0to1: got %b%b expected 01", gnt0, gnt1); end
    req0 = 1; req1 = 0;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL handover_1to0: got %b%b expected 10", gnt0, gnt1); end
    req0 = 0;
    tick();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL release_idle: got %b%b expected 00", gnt0, gnt1); end
    req0 = 1; req1 = 1;
    tick();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errors++; $display("FAIL tie_fair: got %b%b expected 01", gnt0, gnt1); end
  endtask

  task automatic test_read_m1();
    do_reset();
    req1 = 1; re1 = 1; addr1 = INPUT_PORT; bus_data = 8'hFC;
    tick();
    checks++; if (gnt1 !== 1'b1 || read_en !== 1'b1 || addr !== 10'h3FE) begin errors++; $display("FAIL read_strobe: got gnt1=%b re=%b addr=%h expected 1 1 3fe", gnt1, read_en, addr); end
    tick();
    checks++; if (rdata1 !== 8'hFC) begin errors++; $display("FAIL read_capture: got %h expected fc", rdata1); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL read_other_hold: got %h expected 00", rdata0); end
  endtask

  task automatic test_isolation();
    do_reset();
    req1 = 1; we1 = 1; addr1 = 10'h200; wdata1 = 8'h11;
    tick();
    req0 = 1; we0 = 1; addr0 = 10'h055; wdata0 = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (gnt1 !== 1'b1 || write_en !== 1'b1 || addr !== 10'h200 || data !== 8'h11) begin
        errors++; $display("FAIL isolation[%0d]: got gnt1=%b we=%b addr=%h data=%h expected 1 1 200 11", i, gnt1, write_en, addr, data);
      end
      tick();
    end
    re1 = 1; bus_data = 8'h77;
    #1;
    checks++; if (write_en !== 1'b1 || read_en !== 1'b0) begin errors++; $display("FAIL we_re_priority: got we=%b re=%b expected 1 0", write_en, read_en); end
    tick();
    checks++; if (rdata1 !== 8'h00) begin errors++; $display("FAIL we_re_no_capture: got %h expected 00", rdata1); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req0 = 1; req1 = 1; lock0 = 0;
    tick();
    n = 0;
    while (gnt0 === 1'b1 && n < 60) begin n++; tick(); end
    checks++; if (n !== (TO_EN ? TIMEOUT : 60)) begin errors++; $display("FAIL timeout_unlocked: got %0d grant cycles expected %0d", n, TO_EN ? TIMEOUT : 60); end
    checks++; if (gnt1 !== TO_EN) begin errors++; $display("FAIL timeout_swap: got gnt1=%b expected %b", gnt1, TO_EN); end
    do_reset();
    req0 = 1; req1 = 1; lock0 = 1;
    tick();
    n = 0;
    while (gnt0 === 1'b1 && n < 40) begin n++; tick(); end
    checks++; if (n !== 40) begin errors++; $display("FAIL timeout_locked: got %0d grant cycles expected 40", n); end
    lock0 = 0;
    tick();
    checks++; if (gnt1 !== TO_EN || gnt0 !== !TO_EN) begin errors++; $display("FAIL unlock_swap: got %b%b expected %b%b", gnt0, gnt1, !TO_EN, TO_EN); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req0 = 1; re0 = 1; bus_data = 8'h5A;
    tick();
    tick();
    checks++; if (rdata0 !== 8'h5A) begin errors++; $display("FAIL pre_reset_capture: got %h expected 5a", rdata0); end
    re0 = 0; we0 = 1; addr0 = OUTPUT_PORT; wdata0 = 8'h33;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (write_en !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL reset_mid_write: got we=%b gnt0=%b expected 0 0", write_en, gnt0); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL reset_clears_rdata: got %h expected 00", rdata0); end
    @(posedge clk);
    #1 rst = 1'b0;
    req1 = 1;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL first_grant_after_reset: got %b%b expected 10", gnt0, gnt1); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req0 = ~req0;
      if ($urandom_range(3) == 0) req1 = ~req1;
      we0 = 1'($urandom); we1 = 1'($urandom); re0 = 1'($urandom); re1 = 1'($urandom);
      lock0 = 1'($urandom); lock1 = 1'($urandom);
      addr0 = 10'($urandom); addr1 = 10'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom); bus_data = 8'($urandom);
      #1;
      checks++; if (gnt0 !== (m_own == 0) || gnt1 !== (m_own == 1)) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b%b expected owner %0d", i, gnt0, gnt1, m_own); end
      checks++; if (write_en !== exp_we()) begin errors++; $display("FAIL rnd_we[%0d]: got %b expected %b", i, write_en, exp_we()); end
      checks++; if (read_en !== exp_re()) begin errors++; $display("FAIL rnd_re[%0d]: got %b expected %b", i, read_en, exp_re()); end
      checks++; if (addr !== exp_addr() || data !== exp_data()) begin errors++; $display("FAIL rnd_bus[%0d]: got %h/%h expected %h/%h", i, addr, data, exp_addr(), exp_data()); end
      checks++; if (rdata0 !== m_rd0 || rdata1 !== m_rd1) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", i, rdata0, rdata1, m_rd0, m_rd1); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_read_m1();
    test_isolation();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, address bus width.
REQ-002 Parameter DATA_W, default 8, data bus width.
REQ-003 Parameter TIMEOUT, default 15, maximum consecutive grant cycles (used only under ARB_TIMEOUT_EN).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_req0 / in_req1  in  1  bus request; master 0 = CPU, master 1 = loader.
- in_we0 / in_we1  in  1  write enable of master N.
- in_re0 / in_re1  in  1  read enable of master N.
- in_addr0 / in_addr1  in  ADDR_W  address of master N.
- in_wdata0 / in_wdata1  in  DATA_W  write data of master N.
- in_lock0 / in_lock1  in  1  owner requests no forced release.
- in_bus_data  in  DATA_W  read data returned by memory/io ports.
- out_gnt0 / out_gnt1  out  1  registered grant.
- out_write_en, out_read_en  out  1  shared bus strobes.
- out_addr  out  ADDR_W  shared bus address.
- out_data  out  DATA_W  shared bus write data.
- out_rdata0 / out_rdata1  out  DATA_W  registered read data per master.

Function
REQ-005 The state machine SHALL have three states: IDLE, OWN0, OWN1; out_gntN SHALL be 1 exactly in OWNN.
REQ-006 From IDLE, a single request SHALL move to the matching OWN state at the next edge, so the grant follows the request by 1 cycle.
REQ-007 On simultaneous requests from IDLE, the master not served last SHALL win; the last-served register resets to 1, so master 0 wins first.
REQ-008 In OWNN, if in_reqN is 0 at an edge, the state SHALL move to OWN(other) if the other master requests, else to IDLE; there is no idle gap on handover.
REQ-009 In OWNN with in_reqN held, the grant SHALL persist; the other master's request is ignored, except as in REQ-016.
REQ-010 out_write_en SHALL equal in_weN AND in_reqN of the owner; out_read_en SHALL equal in_reN AND in_reqN of the owner; both are combinational from the current state.
REQ-011 out_addr and out_data SHALL mux the owner's in_addrN and in_wdataN; they SHALL be 0 in IDLE.
REQ-012 If the owner asserts we and re together, only out_write_en SHALL assert.
REQ-013 On an edge where out_read_en=1, in_bus_data SHALL be captured into out_rdataN of the owner; the other master's out_rdata SHALL hold.
REQ-014 A non-owner's we/re/addr/data SHALL never reach the bus.
REQ-015 The last-served register SHALL update to N on every entry into OWNN.

Reset
REQ-016 (Timeout; see Configuration.) A 4-bit grant counter SHALL count owner cycles; when it reaches TIMEOUT, the other master is requesting and in_lockN=0, the grant SHALL move to the other master at that edge.
REQ-017 rst=1 SHALL force, asynchronously: state IDLE, out_gnt0=out_gnt1=0, out_rdata0=out_rdata1=0, last-served=1, grant counter=0.
REQ-018 Reset asserted during a bus access SHALL drop out_write_en and out_read_en immediately, with no partial capture.
REQ-019 The first grant after reset release SHALL follow REQ-006 and REQ-007.

Configuration
REQ-020 Macro ARB_TIMEOUT_EN: when defined, REQ-016 applies, the counter clears on every state change, and it saturates at TIMEOUT.
REQ-021 When ARB_TIMEOUT_EN is undefined, no counter SHALL exist and ownership SHALL end only per REQ-008; in_lockN SHALL be ignored.

Structure
REQ-022 A shared package io_bus_pkg SHALL hold the state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), ADDR_W/DATA_W defaults and the IO port addresses (INPUT_PORT 10'h3FE, OUTPUT_PORT 10'h3FF).
REQ-023 The block SHALL use one sub-module, arb_grant_counter, holding the timeout counter and instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Reset, then in_req0=1, we0=1, addr0=10'h3FF, wdata0=8'h8C -> gnt0=1 after 1 edge; out_write_en=1, out_addr=10'h3FF, out_data=8'h8C.
- in_req0 and in_req1 rise on the same edge from IDLE -> gnt0 first; req0 drops -> gnt1 on the next edge, no IDLE cycle.
- Master 1 owns with re1=1, addr1=10'h3FE, in_bus_data=8'hFC -> out_rdata1=8'hFC after the edge; out_rdata0 unchanged (0).
- Master 1 holds the bus with we1=1 while master 0 drives we0=1, addr0=10'h055 -> bus shows only master 1 values; no write to 10'h055.
- ARB_TIMEOUT_EN with both requests held and lock0=0 -> gnt swaps to master 1 after 15 cycles; repeat with lock0=1 -> gnt0 stays for 40 cycles.
- rst pulsed mid-write -> out_write_en=0 and gnt0=0 within the same cycle; out_rdata cleared.
